mem_stage: RTL and testbench
============================

# mem_stage

Memory stage of the 5-stage RISC-V pipeline. It sits between the EX-MEM pipeline buffer and writeback, and it owns the data-memory handshake. It issues load/store requests and aligns the data: byte enables and lane shifting for stores, sign/zero extension for loads. It stalls the upstream stages while a memory access is outstanding, then registers everything writeback needs into the MEM-WB buffer.

## Interface
- No parameters; address and data widths are fixed at 32 bits.
- Reset is synchronous, active-high, one clock.
- clock  in  1  pipeline clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high
- lsu_enable_ip  in  1  instruction is a load or store
- mem_lsu_operator_ip  in  load_store_func_code  one of LB, LH, LW, LBU, LHU, SB, SH, SW
- alu_result_ip  in  32  effective address, or ALU result for non-memory ops
- alu_valid_ip  in  1  EX result is valid
- mem_wdata_ip  in  32  store data (rs2)
- regfile_write_valid_ip  in  1  instruction writes rd
- mem_wb_mux_ip  in  write_back_mux_selector  passed through to WB
- mem_write_reg_addr_ip  in  5  rd, passed through
- mem_pc_addr_ip, mem_uimmd_ip  in  32 each  passed through
- data_req_op  out  1  memory request
- data_addr_op  out  32  word address; bits [1:0] are always 0
- data_we_op  out  1  1 = store
- data_be_op  out  4  byte enables
- data_wdata_op  out  32  lane-shifted store data
- data_gnt_ip  in  1  request accepted
- data_rvalid_ip  in  1  response valid (load data, or store acknowledge)
- data_rdata_ip  in  32  raw load word
- mem_stall_op  out  1  freezes the PC, IF-ID, ID-EX and EX-MEM buffers
- wb_alu_result_op, wb_load_data_op, wb_pc_addr_op, wb_uimmd_op  out  32 each  MEM-WB buffer
- wb_mux_op  out  write_back_mux_selector;  wb_write_reg_addr_op  out  5;  wb_regfile_write_valid_op  out  1
- misaligned_op  out  1  registered one-cycle error pulse

## Operation
- FSM states and transitions:
  - IDLE, WAIT_GNT, WAIT_RVALID.
  - Reset forces IDLE.
- Memory access detection:
  - An access is pending when lsu_enable_ip=1 and alu_valid_ip=1.
  - Alignment rules: LH, LHU and SH need addr[0]=0. LW and SW need addr[1:0]=0. Byte ops are always aligned.
- Aligned access while in IDLE:
  - Drive data_req_op=1, mem_stall_op=1.
  - data_gnt_ip=1 → WAIT_RVALID. data_gnt_ip=0 → WAIT_GNT.
- WAIT_GNT:
  - Keep data_req_op=1 and mem_stall_op=1.
  - Address, we, be and wdata must not change; the stall holds the inputs steady.
  - On data_gnt_ip → WAIT_RVALID.
- WAIT_RVALID:
  - data_req_op=0, mem_stall_op stays 1 until the cycle data_rvalid_ip=1.
  - In that cycle mem_stall_op=0, the MEM-WB buffer captures the result, and the FSM returns to IDLE.
- data_rvalid_ip outside WAIT_RVALID is ignored.
- Misaligned access:
  - No request is issued and mem_stall_op=0.
  - Next cycle misaligned_op=1 and wb_regfile_write_valid_op=0.
- Non-memory op: single-cycle pass-through with mem_stall_op=0.
- Store lane mapping, with off=addr[1:0]:
  - SB: be=4'b0001<<off, wdata={4{wdata[7:0]}}.
  - SH: be=4'b0011<<off, wdata={2{wdata[15:0]}}.
  - SW: be=4'b1111, wdata unchanged.
- Load extraction:
  - Select byte rdata[8*off+:8] or halfword rdata[16*off[1]+:16].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word unchanged.
  - data_be_op for loads uses the same mapping as stores.
- Writeback valid:
  - While mem_stall_op=1, the MEM-WB buffer loads a bubble: wb_regfile_write_valid_op=0, misaligned_op=0, other fields hold their values.
  - Stores always produce wb_regfile_write_valid_op=0.
  - Loads take wb_regfile_write_valid_op from regfile_write_valid_ip.

## Timing
- Reset values, one cycle after reset is asserted:
  - FSM=IDLE.
  - data_req_op=0, data_we_op=0, data_be_op=0, data_addr_op=0, data_wdata_op=0.
  - mem_stall_op=0, misaligned_op=0.
  - All wb_* outputs = 0.
- Reset mid-access aborts the access with no writeback; a late rvalid after reset is ignored.
- data_req_op and mem_stall_op are combinational from FSM state and inputs; all wb_* outputs and misaligned_op are registered.
- Non-memory op or misaligned access: 1 cycle in MEM, wb_* valid on the next edge.
- Memory access latency is 1 + (cycles until gnt) + (cycles from gnt to rvalid), with a minimum of 2 cycles (gnt in the request cycle, rvalid the next cycle).
- rvalid is never expected in the gnt cycle; at most one access is outstanding.
- Back-to-back loads: a second access may request in the cycle after the rvalid of the first.

## Test plan
- Reset:
  - Assert reset for 2 cycles with garbage on the inputs.
  - Expect all outputs 0, FSM IDLE, and no data_req_op.
- LW with immediate handshake:
  - LW at 0x100; gnt in cycle 0, rvalid with 0xDEADBEEF in cycle 1.
  - Expect stall=1 for exactly 1 cycle, be=4'hF, wb_load_data_op=0xDEADBEEF, write valid=1.
- LB and LBU at lane 3:
  - LB at 0x103 with rdata=0x80FF_0000 → wb_load_data_op=0xFFFFFF80.
  - LBU at the same address → 0x00000080.
- SH with delayed grant:
  - SH at 0x102, wdata=0x1234ABCD, gnt held low for 3 cycles.
  - Expect addr=0x100, be=4'b1100, wdata=0xABCDABCD held stable across the wait; stall for 5 cycles; wb write valid=0.
- Misaligned and pass-through:
  - LW at 0x101 → no data_req_op, misaligned_op=1 next cycle, write valid=0.
  - A following ADD result 0x55 passes through to WB in 1 cycle.
- Reset mid-access:
  - Assert reset in WAIT_RVALID, then drive rvalid.
  - Expect IDLE, stall=0, and no writeback.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: data-memory handshake, store lane placement, load extension
// and the MEM-WB pipeline buffer.
package mem_pkg;
  typedef enum logic [2:0] {
    LB, LH, LW, LBU, LHU, SB, SH, SW
  } load_store_func_code;

  typedef enum logic [1:0] {
    WB_ALU, WB_LOAD, WB_PC, WB_UIMM
  } write_back_mux_selector;
endpackage

module mem_stage
  import mem_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   lsu_enable_ip,
  input  load_store_func_code    mem_lsu_operator_ip,
  input  logic [31:0]            alu_result_ip,
  input  logic                   alu_valid_ip,
  input  logic [31:0]            mem_wdata_ip,
  input  logic                   regfile_write_valid_ip,
  input  write_back_mux_selector mem_wb_mux_ip,
  input  logic [4:0]             mem_write_reg_addr_ip,
  input  logic [31:0]            mem_pc_addr_ip,
  input  logic [31:0]            mem_uimmd_ip,
  output logic                   data_req_op,
  output logic [31:0]            data_addr_op,
  output logic                   data_we_op,
  output logic [3:0]             data_be_op,
  output logic [31:0]            data_wdata_op,
  input  logic                   data_gnt_ip,
  input  logic                   data_rvalid_ip,
  input  logic [31:0]            data_rdata_ip,
  output logic                   mem_stall_op,
  output logic [31:0]            wb_alu_result_op,
  output logic [31:0]            wb_load_data_op,
  output logic [31:0]            wb_pc_addr_op,
  output logic [31:0]            wb_uimmd_op,
  output write_back_mux_selector wb_mux_op,
  output logic [4:0]             wb_write_reg_addr_op,
  output logic                   wb_regfile_write_valid_op,
  output logic                   misaligned_op
);

  typedef enum logic [1:0] {
    IDLE, WAIT_GNT, WAIT_RVALID
  } state_t;

  state_t state_q, state_d;

  logic [1:0]  off;
  logic        is_store;
  logic        aligned;
  logic        pending;
  logic        done;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] load_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  logic [31:0] wb_alu_q, wb_alu_d;
  logic [31:0] wb_ld_q, wb_ld_d;
  logic [31:0] wb_pc_q, wb_pc_d;
  logic [31:0] wb_uimm_q, wb_uimm_d;
  write_back_mux_selector wb_mux_q, wb_mux_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_wv_q, wb_wv_d;
  logic        mis_q, mis_d;

  assign off     = alu_result_ip[1:0];
  assign pending = lsu_enable_ip & alu_valid_ip;
  assign done    = (state_q == WAIT_RVALID) & data_rvalid_ip;

  always_comb begin
    is_store = 1'b0;
    aligned  = 1'b1;
    be       = 4'b1111;
    wdata    = mem_wdata_ip;
    unique case (mem_lsu_operator_ip)
      LB, LBU: be = 4'b0001 << off;
      LH, LHU: begin
        aligned = ~off[0];
        be      = 4'b0011 << off;
      end
      LW: aligned = (off == 2'b00);
      SB: begin
        is_store = 1'b1;
        be       = 4'b0001 << off;
        wdata    = {4{mem_wdata_ip[7:0]}};
      end
      SH: begin
        is_store = 1'b1;
        aligned  = ~off[0];
        be       = 4'b0011 << off;
        wdata    = {2{mem_wdata_ip[15:0]}};
      end
      SW: begin
        is_store = 1'b1;
        aligned  = (off == 2'b00);
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte   = data_rdata_ip[8*off +: 8];
    ld_half   = off[1] ? data_rdata_ip[31:16]
                       : data_rdata_ip[15:0];
    load_data = data_rdata_ip;
    unique case (mem_lsu_operator_ip)
      LB:  load_data = {{24{ld_byte[7]}}, ld_byte};
      LBU: load_data = {24'd0, ld_byte};
      LH:  load_data = {{16{ld_half[15]}}, ld_half};
      LHU: load_data = {16'd0, ld_half};
      default: ;
    endcase
  end

  // Request/stall are combinational; reset masks them so garbage
  // inputs during reset never reach memory or the hazard logic.
  always_comb begin
    state_d      = state_q;
    data_req_op  = 1'b0;
    mem_stall_op = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pending && aligned) begin
          data_req_op  = 1'b1;
          mem_stall_op = 1'b1;
          state_d      = data_gnt_ip ? WAIT_RVALID : WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        data_req_op  = 1'b1;
        mem_stall_op = 1'b1;
        if (data_gnt_ip) state_d = WAIT_RVALID;
      end
      WAIT_RVALID: begin
        mem_stall_op = ~data_rvalid_ip;
        if (data_rvalid_ip) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      data_req_op  = 1'b0;
      mem_stall_op = 1'b0;
    end
  end

  assign data_addr_op  = data_req_op ? {alu_result_ip[31:2], 2'b00} : '0;
  assign data_we_op    = data_req_op & is_store;
  assign data_be_op    = data_req_op ? be : 4'b0000;
  assign data_wdata_op = data_req_op ? wdata : '0;

  always_comb begin
    wb_alu_d  = wb_alu_q;
    wb_ld_d   = wb_ld_q;
    wb_pc_d   = wb_pc_q;
    wb_uimm_d = wb_uimm_q;
    wb_mux_d  = wb_mux_q;
    wb_rd_d   = wb_rd_q;
    wb_wv_d   = 1'b0;
    mis_d     = 1'b0;
    if (!mem_stall_op) begin
      wb_alu_d  = alu_result_ip;
      wb_ld_d   = (done && !is_store) ? load_data : '0;
      wb_pc_d   = mem_pc_addr_ip;
      wb_uimm_d = mem_uimmd_ip;
      wb_mux_d  = mem_wb_mux_ip;
      wb_rd_d   = mem_write_reg_addr_ip;
      if (pending) begin
        mis_d   = ~aligned;
        wb_wv_d = aligned & ~is_store & regfile_write_valid_ip;
      end else begin
        wb_wv_d = alu_valid_ip & regfile_write_valid_ip;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      wb_alu_q  <= '0;
      wb_ld_q   <= '0;
      wb_pc_q   <= '0;
      wb_uimm_q <= '0;
      wb_mux_q  <= WB_ALU;
      wb_rd_q   <= '0;
      wb_wv_q   <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wb_alu_q  <= wb_alu_d;
      wb_ld_q   <= wb_ld_d;
      wb_pc_q   <= wb_pc_d;
      wb_uimm_q <= wb_uimm_d;
      wb_mux_q  <= wb_mux_d;
      wb_rd_q   <= wb_rd_d;
      wb_wv_q   <= wb_wv_d;
      mis_q     <= mis_d;
    end
  end

  assign wb_alu_result_op          = wb_alu_q;
  assign wb_load_data_op           = wb_ld_q;
  assign wb_pc_addr_op             = wb_pc_q;
  assign wb_uimmd_op               = wb_uimm_q;
  assign wb_mux_op                 = wb_mux_q;
  assign wb_write_reg_addr_op      = wb_rd_q;
  assign wb_regfile_write_valid_op = wb_wv_q;
  assign misaligned_op             = mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: handshake timing, lane mapping,
// extension, misalignment, pass-through and reset abort.
module tb_mem_stage;
  import mem_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic lsu_enable_ip;
  load_store_func_code op_ip;
  logic [31:0] alu_result_ip;
  logic alu_valid_ip;
  logic [31:0] mem_wdata_ip;
  logic rfv_ip;
  write_back_mux_selector mux_ip;
  logic [4:0] rd_ip;
  logic [31:0] pc_ip, uimm_ip;
  logic data_req_op, data_we_op;
  logic [31:0] data_addr_op, data_wdata_op;
  logic [3:0] data_be_op;
  logic data_gnt_ip, data_rvalid_ip;
  logic [31:0] data_rdata_ip;
  logic mem_stall_op;
  logic [31:0] wb_alu, wb_ld, wb_pc, wb_uimm;
  write_back_mux_selector wb_mux;
  logic [4:0] wb_rd;
  logic wb_wv, misaligned_op;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] ld;
    logic [4:0]  rd;
    logic        wv;
    logic        mis;
  } exp_t;

  exp_t sb_q[$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  mem_stage dut (
    .clock(clock), .reset(reset),
    .lsu_enable_ip(lsu_enable_ip),
    .mem_lsu_operator_ip(op_ip),
    .alu_result_ip(alu_result_ip),
    .alu_valid_ip(alu_valid_ip),
    .mem_wdata_ip(mem_wdata_ip),
    .regfile_write_valid_ip(rfv_ip),
    .mem_wb_mux_ip(mux_ip),
    .mem_write_reg_addr_ip(rd_ip),
    .mem_pc_addr_ip(pc_ip),
    .mem_uimmd_ip(uimm_ip),
    .data_req_op(data_req_op),
    .data_addr_op(data_addr_op),
    .data_we_op(data_we_op),
    .data_be_op(data_be_op),
    .data_wdata_op(data_wdata_op),
    .data_gnt_ip(data_gnt_ip),
    .data_rvalid_ip(data_rvalid_ip),
    .data_rdata_ip(data_rdata_ip),
    .mem_stall_op(mem_stall_op),
    .wb_alu_result_op(wb_alu),
    .wb_load_data_op(wb_ld),
    .wb_pc_addr_op(wb_pc),
    .wb_uimmd_op(wb_uimm),
    .wb_mux_op(wb_mux),
    .wb_write_reg_addr_op(wb_rd),
    .wb_regfile_write_valid_op(wb_wv),
    .misaligned_op(misaligned_op)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    lsu_enable_ip = 1'b0;
    alu_valid_ip  = 1'b0;
    rfv_ip        = 1'b0;
    data_gnt_ip   = 1'b0;
    data_rvalid_ip = 1'b0;
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_alu"}, wb_alu, e.alu);
    chk({tag, "_ld"}, wb_ld, e.ld);
    chk({tag, "_rd"}, {27'd0, wb_rd}, {27'd0, e.rd});
    chk({tag, "_wv"}, {31'd0, wb_wv}, {31'd0, e.wv});
    chk({tag, "_mis"}, {31'd0, misaligned_op}, {31'd0, e.mis});
  endtask

  task automatic mem_op(input string tag, input load_store_func_code op,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rword, input int gdly,
                        input int rdly, input logic [3:0] ebe,
                        input logic [31:0] ewd, input logic [31:0] eld);
    int stalls = 0;
    logic st;
    st = (op == SB) || (op == SH) || (op == SW);
    lsu_enable_ip = 1'b1;
    alu_valid_ip  = 1'b1;
    op_ip         = op;
    alu_result_ip = addr;
    mem_wdata_ip  = wd;
    rfv_ip        = 1'b1;
    rd_ip         = 5'd7;
    mux_ip        = WB_LOAD;
    sb_q.push_back('{alu: addr, ld: st ? 32'd0 : eld, rd: 5'd7,
                     wv: ~st, mis: 1'b0});
    for (int c = 0; c <= gdly; c++) begin
      data_gnt_ip = (c == gdly);
      #1;
      chk({tag, "_req"}, {31'd0, data_req_op}, 32'd1);
      chk({tag, "_addr"}, data_addr_op, {addr[31:2], 2'b00});
      chk({tag, "_be"}, {28'd0, data_be_op}, {28'd0, ebe});
      chk({tag, "_wd"}, data_wdata_op, ewd);
      chk({tag, "_we"}, {31'd0, data_we_op}, {31'd0, st});
      stalls += int'(mem_stall_op);
      tick();
    end
    data_gnt_ip = 1'b0;
    for (int c = 1; c < rdly; c++) begin
      #1;
      stalls += int'(mem_stall_op);
      tick();
    end
    data_rvalid_ip = 1'b1;
    data_rdata_ip  = rword;
    #1;
    chk({tag, "_req_rv"}, {31'd0, data_req_op}, 32'd0);
    chk({tag, "_stall_rv"}, {31'd0, mem_stall_op}, 32'd0);
    tick();
    idle_in();
    pop_chk(tag);
    chk({tag, "_stall_cnt"}, stalls, gdly + rdly);
  endtask

  initial begin
    reset = 1'b1;
    lsu_enable_ip = 1'b1;
    alu_valid_ip  = 1'b1;
    op_ip         = LW;
    alu_result_ip = 32'hCAFE_0000;
    mem_wdata_ip  = 32'hFFFF_FFFF;
    rfv_ip        = 1'b1;
    mux_ip        = WB_PC;
    rd_ip         = 5'd31;
    pc_ip         = 32'h1234_5678;
    uimm_ip       = 32'h8765_4321;
    data_gnt_ip   = 1'b1;
    data_rvalid_ip = 1'b1;
    data_rdata_ip = 32'hA5A5_A5A5;
    tick();
    tick();
    chk("rst_req", {31'd0, data_req_op}, 32'd0);
    chk("rst_stall", {31'd0, mem_stall_op}, 32'd0);
    chk("rst_addr", data_addr_op, 32'd0);
    chk("rst_be", {28'd0, data_be_op}, 32'd0);
    chk("rst_wd", data_wdata_op, 32'd0);
    chk("rst_we", {31'd0, data_we_op}, 32'd0);
    chk("rst_wb_alu", wb_alu, 32'd0);
    chk("rst_wb_ld", wb_ld, 32'd0);
    chk("rst_wb_pc", wb_pc, 32'd0);
    chk("rst_wb_uimm", wb_uimm, 32'd0);
    chk("rst_wb_mux", {30'd0, wb_mux}, 32'd0);
    chk("rst_wb_wv", {31'd0, wb_wv}, 32'd0);
    chk("rst_mis", {31'd0, misaligned_op}, 32'd0);
    idle_in();
    pc_ip   = 32'h0;
    uimm_ip = 32'h0;
    reset = 1'b0;
    tick();

    mem_op("lw", LW, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 1,
           4'hF, 32'h0, 32'hDEAD_BEEF);
    mem_op("lb", LB, 32'h103, 32'h0, 32'h80FF_0000, 0, 1,
           4'b1000, 32'h0, 32'hFFFF_FF80);
    mem_op("lbu", LBU, 32'h103, 32'h0, 32'h80FF_0000, 0, 1,
           4'b1000, 32'h0, 32'h0000_0080);
    mem_op("lh", LH, 32'h102, 32'h0, 32'h9234_0000, 1, 2,
           4'b1100, 32'h0, 32'hFFFF_9234);
    mem_op("sh", SH, 32'h102, 32'h1234_ABCD, 32'h0, 3, 2,
           4'b1100, 32'hABCD_ABCD, 32'h0);
    mem_op("sb", SB, 32'h101, 32'h0000_00EF, 32'h0, 0, 1,
           4'b0010, 32'hEFEF_EFEF, 32'h0);

    lsu_enable_ip = 1'b1;
    alu_valid_ip  = 1'b1;
    op_ip         = LW;
    alu_result_ip = 32'h101;
    rfv_ip        = 1'b1;
    rd_ip         = 5'd3;
    data_gnt_ip   = 1'b1;
    sb_q.push_back('{alu: 32'h101, ld: 32'h0, rd: 5'd3,
                     wv: 1'b0, mis: 1'b1});
    #1;
    chk("mis_req", {31'd0, data_req_op}, 32'd0);
    chk("mis_stall", {31'd0, mem_stall_op}, 32'd0);
    tick();
    data_gnt_ip   = 1'b0;
    lsu_enable_ip = 1'b0;
    alu_valid_ip  = 1'b1;
    alu_result_ip = 32'h55;
    rd_ip         = 5'd9;
    sb_q.push_back('{alu: 32'h55, ld: 32'h0, rd: 5'd9,
                     wv: 1'b1, mis: 1'b0});
    pop_chk("mis");
    #1;
    chk("add_stall", {31'd0, mem_stall_op}, 32'd0);
    tick();
    idle_in();
    pop_chk("add");

    lsu_enable_ip = 1'b1;
    alu_valid_ip  = 1'b1;
    op_ip         = LW;
    alu_result_ip = 32'h200;
    rfv_ip        = 1'b1;
    data_gnt_ip   = 1'b1;
    tick();
    data_gnt_ip = 1'b0;
    #1;
    chk("mid_stall_pre", {31'd0, mem_stall_op}, 32'd1);
    reset = 1'b1;
    idle_in();
    tick();
    reset = 1'b0;
    data_rvalid_ip = 1'b1;
    data_rdata_ip  = 32'h1111_2222;
    #1;
    chk("mid_stall", {31'd0, mem_stall_op}, 32'd0);
    chk("mid_req", {31'd0, data_req_op}, 32'd0);
    tick();
    data_rvalid_ip = 1'b0;
    chk("mid_wv", {31'd0, wb_wv}, 32'd0);
    chk("mid_ld", wb_ld, 32'd0);

    mem_op("post", LW, 32'h300, 32'h0, 32'h0BAD_F00D, 0, 1,
           4'hF, 32'h0, 32'h0BAD_F00D);
    chk("sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
